// File: rtl/bcd_timer_core.sv
// M:SS.t stopwatch/timer core: preset entry, up/down count to a goal, pause,
// lap freeze, auto-reload and a one-cycle terminal-count pulse.
module bcd_timer_core #(
    parameter int TICK_DIV = 10000000,
    parameter int MIN_W    = 4,
    parameter int MAX_MIN  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir_toggle,
    input  logic             inc,
    input  logic             enter,
    input  logic             lap,
    input  logic             auto_reload,
    output logic [MIN_W-1:0] disp_min,
    output logic [3:0]       disp_tens,
    output logic [3:0]       disp_sec,
    output logic [3:0]       disp_tenth,
    output logic             blank,
    output logic             countdown,
    output logic [2:0]       state,
    output logic             done,
    output logic             lap_active
);
    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SET_MIN   = 3'd1,
        SET_TENS  = 3'd2,
        SET_SEC   = 3'd3,
        SET_TENTH = 3'd4,
        RUN       = 3'd5,
        DONE      = 3'd6
    } state_t;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [3:0]       tens;
        logic [3:0]       sec;
        logic [3:0]       tenth;
    } bcd_time_t;

    state_t           state_reg, state_next;
    bcd_time_t        cur_reg, cur_next;
    bcd_time_t        goal_reg, goal_next;
    bcd_time_t        lap_reg, lap_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             countdown_reg, countdown_next;
    logic             done_reg, done_next;
    logic             lap_active_reg, lap_active_next;

    bcd_time_t start_val, target_val, stepped, disp_sel;
    logic      tick;

    function automatic bcd_time_t step_up(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenth != 4'd9) begin
            r.tenth = t.tenth + 4'd1;
        end else begin
            r.tenth = 4'd0;
            if (t.sec != 4'd9) begin
                r.sec = t.sec + 4'd1;
            end else begin
                r.sec = 4'd0;
                if (t.tens != 4'd5) begin
                    r.tens = t.tens + 4'd1;
                end else begin
                    r.tens = 4'd0;
                    r.min  = (t.min == MAX_MIN_V) ? '0 : t.min + MIN_W'(1);
                end
            end
        end
        return r;
    endfunction

    // Borrow chain mirrors the carry chain of step_up.
    function automatic bcd_time_t step_down(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenth != 4'd0) begin
            r.tenth = t.tenth - 4'd1;
        end else begin
            r.tenth = 4'd9;
            if (t.sec != 4'd0) begin
                r.sec = t.sec - 4'd1;
            end else begin
                r.sec = 4'd9;
                if (t.tens != 4'd0) begin
                    r.tens = t.tens - 4'd1;
                end else begin
                    r.tens = 4'd5;
                    r.min  = (t.min == '0) ? MAX_MIN_V : t.min - MIN_W'(1);
                end
            end
        end
        return r;
    endfunction

    assign start_val  = countdown_reg ? goal_reg : '0;
    assign target_val = countdown_reg ? '0 : goal_reg;
    assign stepped    = countdown_reg ? step_down(cur_reg) : step_up(cur_reg);

    always_comb begin
        state_next      = state_reg;
        cur_next        = cur_reg;
        goal_next       = goal_reg;
        lap_next        = lap_reg;
        lap_active_next = lap_active_reg;
        cnt_next        = cnt_reg;
        countdown_next  = countdown_reg;
        done_next       = 1'b0;
        tick            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dir_toggle) countdown_next = ~countdown_reg;
                if (enter) begin
                    cur_next   = '0;
                    goal_next  = '0;
                    state_next = SET_MIN;
                end
            end
            SET_MIN: begin
                if (inc)        cur_next.min = (cur_reg.min == MAX_MIN_V) ? '0 : cur_reg.min + MIN_W'(1);
                else if (enter) state_next = SET_TENS;
            end
            SET_TENS: begin
                if (inc)        cur_next.tens = (cur_reg.tens == 4'd5) ? 4'd0 : cur_reg.tens + 4'd1;
                else if (enter) state_next = SET_SEC;
            end
            SET_SEC: begin
                if (inc)        cur_next.sec = (cur_reg.sec == 4'd9) ? 4'd0 : cur_reg.sec + 4'd1;
                else if (enter) state_next = SET_TENTH;
            end
            SET_TENTH: begin
                if (inc) begin
                    cur_next.tenth = (cur_reg.tenth == 4'd9) ? 4'd0 : cur_reg.tenth + 4'd1;
                end else if (enter) begin
                    goal_next = cur_reg;
                    cur_next  = countdown_reg ? cur_reg : '0;
                    cnt_next  = '0;
                    if (cur_reg == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Lap samples cur before any step taken on this same cycle.
                if (lap) begin
                    if (!lap_active_reg) begin
                        lap_next        = cur_reg;
                        lap_active_next = 1'b1;
                    end else begin
                        lap_active_next = 1'b0;
                    end
                end
                if (en) begin
                    tick     = (cnt_reg == TICK_LAST);
                    cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
                    if (tick) begin
                        if (stepped == target_val) begin
                            done_next = 1'b1;
                            if (auto_reload) begin
                                cur_next = start_val;
                            end else begin
                                cur_next        = stepped;
                                state_next      = DONE;
                                lap_active_next = 1'b0;
                            end
                        end else begin
                            cur_next = stepped;
                        end
                    end
                end
            end
            DONE: begin
                if (enter) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_reg        <= '0;
            goal_reg       <= '0;
            lap_reg        <= '0;
            cnt_reg        <= '0;
            countdown_reg  <= 1'b0;
            done_reg       <= 1'b0;
            lap_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_reg        <= cur_next;
            goal_reg       <= goal_next;
            lap_reg        <= lap_next;
            cnt_reg        <= cnt_next;
            countdown_reg  <= countdown_next;
            done_reg       <= done_next;
            lap_active_reg <= lap_active_next;
        end
    end

    assign disp_sel   = lap_active_reg ? lap_reg : cur_reg;
    assign disp_min   = disp_sel.min;
    assign disp_tens  = disp_sel.tens;
    assign disp_sec   = disp_sel.sec;
    assign disp_tenth = disp_sel.tenth;
    assign blank      = (state_reg == IDLE);
    assign countdown  = countdown_reg;
    assign state      = state_reg;
    assign done       = done_reg;
    assign lap_active = lap_active_reg;
endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: a tenths-as-integer timer model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bcd_timer_core;
    localparam int TICK_DIV = 4;
    localparam int MIN_W    = 4;
    localparam int MAX_MIN  = 9;

    logic             clk = 1'b0;
    logic             rst, en, dir_toggle, inc, enter, lap, auto_reload;
    logic [MIN_W-1:0] disp_min;
    logic [3:0]       disp_tens, disp_sec, disp_tenth;
    logic             blank, countdown, done, lap_active;
    logic [2:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    bcd_timer_core #(.TICK_DIV(TICK_DIV), .MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .rst(rst), .en(en), .dir_toggle(dir_toggle), .inc(inc),
        .enter(enter), .lap(lap), .auto_reload(auto_reload),
        .disp_min(disp_min), .disp_tens(disp_tens), .disp_sec(disp_sec),
        .disp_tenth(disp_tenth), .blank(blank), .countdown(countdown),
        .state(state), .done(done), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    // Model: times are plain integers in tenths of a second.
    int m_state, m_cur, m_goal, m_lap, m_cnt;
    bit m_cd, m_done, m_lapact;

    function automatic int bump(input int t, input int st);
        int mn, tn, s, th;
        mn = t / 600; tn = (t / 100) % 6; s = (t / 10) % 10; th = t % 10;
        case (st)
            1:       mn = (mn + 1) % (MAX_MIN + 1);
            2:       tn = (tn + 1) % 6;
            3:       s  = (s + 1) % 10;
            default: th = (th + 1) % 10;
        endcase
        return mn * 600 + tn * 100 + s * 10 + th;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cur = 0; m_goal = 0; m_lap = 0; m_cnt = 0;
        m_cd = 0; m_done = 0; m_lapact = 0;
    endtask

    task automatic model_advance();
        bit nd;
        int nxt;
        nd = 0;
        case (m_state)
            0: begin
                if (dir_toggle) m_cd = !m_cd;
                if (enter) begin m_cur = 0; m_goal = 0; m_state = 1; end
            end
            1, 2, 3, 4: begin
                if (inc) m_cur = bump(m_cur, m_state);
                else if (enter) begin
                    if (m_state < 4) m_state++;
                    else begin
                        m_goal = m_cur;
                        m_cur  = m_cd ? m_goal : 0;
                        m_cnt  = 0;
                        if (m_goal == 0) begin m_state = 6; nd = 1; end
                        else m_state = 5;
                    end
                end
            end
            5: begin
                if (lap) begin
                    if (!m_lapact) begin m_lap = m_cur; m_lapact = 1; end
                    else m_lapact = 0;
                end
                if (en) begin
                    if (m_cnt == TICK_DIV - 1) begin
                        m_cnt = 0;
                        nxt = m_cd ? m_cur - 1 : m_cur + 1;
                        if (nxt == (m_cd ? 0 : m_goal)) begin
                            nd = 1;
                            if (auto_reload) m_cur = m_cd ? m_goal : 0;
                            else begin m_cur = nxt; m_state = 6; m_lapact = 0; end
                        end else m_cur = nxt;
                    end else m_cnt++;
                end
            end
            6: if (enter) m_state = 0;
            default: m_state = 0;
        endcase
        m_done = nd;
    endtask

    logic [22:0] act_v, exp_v;
    int v;

    // Compare on the falling edge, then predict the next rising edge's result.
    always @(negedge clk) begin
        if (rst) model_reset();
        v = m_lapact ? m_lap : m_cur;
        exp_v = {4'(v / 600), 4'((v / 100) % 6), 4'((v / 10) % 10), 4'(v % 10),
                 (m_state == 0), m_cd, 3'(m_state), m_done, m_lapact};
        act_v = {disp_min, disp_tens, disp_sec, disp_tenth, blank, countdown, state, done, lap_active};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, act_v, exp_v);
        end
        if (!rst) model_advance();
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // which: 0 inc, 1 enter, 2 dir_toggle, 3 lap
    task automatic press(input int which, input int n);
        repeat (n) begin
            case (which)
                0: inc = 1'b1;
                1: enter = 1'b1;
                2: dir_toggle = 1'b1;
                default: lap = 1'b1;
            endcase
            tick_clk(1);
            inc = 1'b0; enter = 1'b0; dir_toggle = 1'b0; lap = 1'b0;
        end
    endtask

    // Returns the number of cycles until done is seen, or -1 if the bound expires.
    task automatic wait_done(input int limit, output int k);
        int c;
        k = -1;
        for (c = 1; c <= limit; c++) begin
            tick_clk(1);
            if (done) begin k = c; break; end
        end
    endtask

    initial begin
        int k, pulses, first;
        rst = 1'b1; en = 1'b1; dir_toggle = 1'b0; inc = 1'b0;
        enter = 1'b0; lap = 1'b0; auto_reload = 1'b0;
        tick_clk(2);
        check("reset_state", state, 0);
        check("reset_blank", blank, 1);
        check("reset_disp", {disp_min, disp_tens, disp_sec, disp_tenth}, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        tick_clk(1);

        // Up count to 0:00.3
        press(1, 4);
        check("set_tenth_state", state, 4);
        press(0, 3);
        check("set_tenth_val", disp_tenth, 3);
        press(1, 1);
        check("up_run_state", state, 5);
        check("up_run_start", disp_tenth, 0);
        wait_done(50, k);
        check("up_done_latency", k, 12);
        check("up_done_state", state, 6);
        check("up_done_disp", disp_tenth, 3);
        press(1, 1);
        check("done_to_idle_blank", blank, 1);

        // Field wrap, inc+enter priority, then reset mid-RUN
        press(1, 1);
        press(0, 10);
        check("min_wrap", disp_min, 0);
        press(0, 3);
        inc = 1'b1; enter = 1'b1; tick_clk(1); inc = 1'b0; enter = 1'b0;
        check("inc_enter_min", disp_min, 4);
        check("inc_enter_state", state, 1);
        press(1, 1);
        press(0, 6);
        check("tens_wrap", disp_tens, 0);
        press(0, 2);
        press(1, 1);
        press(0, 10);
        check("sec_wrap", disp_sec, 0);
        press(0, 1);
        press(1, 2);
        check("run_421", state, 5);
        tick_clk(10);
        check("run_421_tenth", disp_tenth, 2);
        rst = 1'b1; #1;
        check("async_rst_state", state, 0);
        check("async_rst_blank", blank, 1);
        check("async_rst_disp", {disp_min, disp_tens, disp_sec, disp_tenth}, 0);
        check("async_rst_done", done, 0);
        tick_clk(1);
        rst = 1'b0;
        tick_clk(1);

        // Count down from 1:00.0
        press(2, 1);
        check("dir_toggle", countdown, 1);
        press(1, 1);
        press(0, 1);
        press(1, 4);
        check("down_start_min", disp_min, 1);
        tick_clk(4);
        check("down_first_tick", {disp_min, disp_tens, disp_sec, disp_tenth}, 16'h0599);
        wait_done(3000, k);
        check("down_done_latency", k, 2396);
        check("down_done_disp", {disp_min, disp_tens, disp_sec, disp_tenth}, 0);
        check("down_done_state", state, 6);
        tick_clk(1);
        check("down_done_one_cycle", done, 0);
        press(1, 1);
        check("countdown_kept", countdown, 1);
        press(2, 1);
        check("dir_back_up", countdown, 0);

        // Pause and lap with goal 0:03.0 counting up
        press(1, 3);
        press(0, 3);
        press(1, 2);
        tick_clk(22);
        check("pre_pause_tenth", disp_tenth, 5);
        en = 1'b0;
        tick_clk(50);
        check("paused_tenth", disp_tenth, 5);
        en = 1'b1;
        tick_clk(1);
        check("resume_hold", disp_tenth, 5);
        tick_clk(1);
        check("resume_tick", disp_tenth, 6);
        tick_clk(25);
        press(3, 1);
        check("lap_on", lap_active, 1);
        check("lap_disp", {disp_sec, disp_tenth}, 8'h12);
        tick_clk(31);
        check("lap_frozen", {disp_sec, disp_tenth}, 8'h12);
        press(3, 1);
        check("lap_off", lap_active, 0);
        check("lap_release_disp", {disp_sec, disp_tenth}, 8'h20);
        wait_done(100, k);
        check("lap_run_done", k, 38);
        press(3, 1);
        check("lap_ignored_done", lap_active, 0);
        press(1, 1);

        // Auto-reload with goal 0:00.2
        auto_reload = 1'b1;
        press(1, 4);
        press(0, 2);
        press(1, 1);
        pulses = 0; first = -1;
        for (int c = 1; c <= 24; c++) begin
            tick_clk(1);
            if (done) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check("reload_pulses", pulses, 3);
        check("reload_first", first, 8);
        check("reload_state", state, 5);
        auto_reload = 1'b0;
        wait_done(20, k);
        check("reload_off_done", k, 8);
        check("reload_off_state", state, 6);
        press(1, 1);

        // Zero goal goes straight to DONE
        press(1, 5);
        check("zero_goal_state", state, 6);
        check("zero_goal_done", done, 1);
        tick_clk(1);
        check("zero_goal_done_clear", done, 0);
        press(1, 1);
        check("zero_goal_idle", state, 0);

        tick_clk(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
